// File: rtl/shadow_pkg.sv
// Shared constants and entry format for bank 00/01 -> E0/E1 video shadowing.
package shadow_pkg;

  localparam int unsigned SH_TEXT1  = 0;
  localparam int unsigned SH_HGR1   = 1;
  localparam int unsigned SH_HGR2   = 2;
  localparam int unsigned SH_SHR    = 3;
  localparam int unsigned SH_AUXHGR = 4;
  localparam int unsigned SH_TEXT2  = 5;

  localparam logic [15:0] TEXT1_LO = 16'h0400;
  localparam logic [15:0] TEXT1_HI = 16'h07FF;
  localparam logic [15:0] TEXT2_LO = 16'h0800;
  localparam logic [15:0] TEXT2_HI = 16'h0BFF;
  localparam logic [15:0] HGR1_LO  = 16'h2000;
  localparam logic [15:0] HGR1_HI  = 16'h3FFF;
  localparam logic [15:0] HGR2_LO  = 16'h4000;
  localparam logic [15:0] HGR2_HI  = 16'h5FFF;
  localparam logic [15:0] SHR_LO   = 16'h2000;
  localparam logic [15:0] SHR_HI   = 16'h9FFF;

  localparam int unsigned ENTRY_W = 25;

  typedef struct packed {
    logic        bank0;
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/shadow_writer_if.sv
// CPU bus in, slow-RAM write port and stall out; master is the CPU/memory side.
interface shadow_writer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          fast_clk;
  logic [7:0]    bank;
  logic [15:0]   addr;
  logic [7:0]    dout;
  logic          we;
  logic [7:0]    shadow;
  logic [16:0]   sr_addr;
  logic [7:0]    sr_din;
  logic          sr_we;
  logic          cpu_wait;
  logic [LW-1:0] fifo_level;

  modport master (
    output fast_clk, bank, addr, dout, we, shadow,
    input  sr_addr, sr_din, sr_we, cpu_wait, fifo_level
  );

  modport slave (
    input  fast_clk, bank, addr, dout, we, shadow,
    output sr_addr, sr_din, sr_we, cpu_wait, fifo_level
  );
endinterface

// File: rtl/shadow_writer_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop happens the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/shadow_writer.sv
// Captures CPU writes to shadowed video regions and replays them into slow RAM
// at the slot rate, stalling the CPU on overflow or on E0/E1 reads with writes pending.
module shadow_writer
  import shadow_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SLOW_DIV = 14
) (
  input logic             clk_sys,
  input logic             reset_n,
  shadow_writer_if.slave  bus
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = $clog2(SLOW_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SLOW_DIV - 1);

  logic [DW-1:0] div_q;
  logic          pend_q, pend_n;
  logic          skid_valid_q, skid_valid_n, skid_load;
  entry_t        skid_q;
  logic          hold_q, hold_n;
  logic          sr_we_q;
  logic [16:0]   sr_addr_q;
  logic [7:0]    sr_din_q;
  logic          cpu_wait_q, wait_n;

  logic          lo_bank, aux_bank, io_bank, aux_ok, region;
  logic          hit, direct, rd_req, tick, drain_req;
  entry_t        cpu_entry, fifo_wdata, head;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LW-1:0] level;
  logic          unused_shadow;

  assign unused_shadow = ^bus.shadow[7:6];

  // Region decode: hires pages on bank 01 also need the aux-hires enable
  always_comb begin
    lo_bank  = (bus.bank == 8'h00);
    aux_bank = (bus.bank == 8'h01);
    io_bank  = (bus.bank == 8'hE0) | (bus.bank == 8'hE1);
    aux_ok   = lo_bank | ~bus.shadow[SH_AUXHGR];
    region   = (in_range(bus.addr, TEXT1_LO, TEXT1_HI) & ~bus.shadow[SH_TEXT1])
             | (in_range(bus.addr, TEXT2_LO, TEXT2_HI) & ~bus.shadow[SH_TEXT2])
             | (in_range(bus.addr, HGR1_LO, HGR1_HI) & ~bus.shadow[SH_HGR1] & aux_ok)
             | (in_range(bus.addr, HGR2_LO, HGR2_HI) & ~bus.shadow[SH_HGR2] & aux_ok)
             | (in_range(bus.addr, SHR_LO, SHR_HI) & ~bus.shadow[SH_SHR] & aux_bank);
    hit      = bus.fast_clk & bus.we & (lo_bank | aux_bank) & region;
    direct   = bus.fast_clk & io_bank;
    rd_req   = direct & ~bus.we;
    tick     = (div_q == DIV_LAST);
  end

  assign cpu_entry = '{bank0: bus.bank[0], addr: bus.addr, data: bus.dout};

  // Drain, skid and stall control
  always_comb begin
    fifo_push    = 1'b0;
    fifo_wdata   = cpu_entry;
    skid_valid_n = skid_valid_q;
    skid_load    = 1'b0;

    drain_req = tick | pend_q;
    fifo_pop  = drain_req & ~fifo_empty & ~direct;
    pend_n    = drain_req & ~fifo_empty & direct;

    if (skid_valid_q) begin
      if (!fifo_full) begin
        fifo_push    = 1'b1;
        fifo_wdata   = skid_q;
        skid_valid_n = 1'b0;
      end
    end else if (hit) begin
      if (!fifo_full || fifo_pop) begin
        fifo_push = 1'b1;
      end else begin
        skid_valid_n = 1'b1;
        skid_load    = 1'b1;
      end
    end

    hold_n = (hold_q | rd_req) & (~fifo_empty | skid_valid_q);
    wait_n = skid_valid_n | hold_n;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      div_q        <= '0;
      pend_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      hold_q       <= 1'b0;
      sr_we_q      <= 1'b0;
      sr_addr_q    <= '0;
      sr_din_q     <= '0;
      cpu_wait_q   <= 1'b0;
    end else begin
      div_q        <= tick ? '0 : div_q + DW'(1);
      pend_q       <= pend_n;
      skid_valid_q <= skid_valid_n;
      hold_q       <= hold_n;
      cpu_wait_q   <= wait_n;
      sr_we_q      <= fifo_pop;
      if (skid_load) skid_q <= cpu_entry;
      if (fifo_pop) begin
        sr_addr_q <= {head.bank0, head.addr};
        sr_din_q  <= head.data;
      end
    end
  end

  assign bus.sr_we      = sr_we_q;
  assign bus.sr_addr    = sr_addr_q;
  assign bus.sr_din     = sr_din_q;
  assign bus.cpu_wait   = cpu_wait_q;
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_shadow_writer.sv
// Directed and random checks of shadow_writer against a queue-based model of shadowed writes.
module tb_shadow_writer;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned SLOW_DIV = 14;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  shadow_writer_if #(.DEPTH(DEPTH)) bus();

  shadow_writer #(.DEPTH(DEPTH), .SLOW_DIV(SLOW_DIV)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_we     = 0;
  int          model_div = 0;
  bit          last_tick;
  logic [24:0] exp_q[$];

  logic [7:0]  rnd_banks [6] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'hE0, 8'h02};
  logic [15:0] rnd_addrs [14] = '{16'h03FF, 16'h0400, 16'h07FF, 16'h0800, 16'h0BFF, 16'h0C00,
                                  16'h1FFF, 16'h2000, 16'h3FFF, 16'h4000, 16'h5FFF, 16'h6000,
                                  16'h9FFF, 16'hA000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_hit(input logic [7:0] b, input logic [15:0] a,
                                   input logic [7:0] sh);
    int x   = int'(a);
    bit aux = (b == 8'h01);
    if (b != 8'h00 && !aux) return 1'b0;
    if (x >= 'h0400 && x <= 'h07FF && !sh[0]) return 1'b1;
    if (x >= 'h0800 && x <= 'h0BFF && !sh[5]) return 1'b1;
    if (x >= 'h2000 && x <= 'h3FFF && !sh[1] && !(aux && sh[4])) return 1'b1;
    if (x >= 'h4000 && x <= 'h5FFF && !sh[2] && !(aux && sh[4])) return 1'b1;
    if (aux && x >= 'h2000 && x <= 'h9FFF && !sh[3]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    bus.fast_clk = 1'b0;
    bus.we       = 1'b0;
    bus.bank     = 8'h00;
    bus.addr     = 16'h0000;
    bus.dout     = 8'h00;
  endtask

  // One clock; every slow-RAM write seen must be the oldest expected write
  task automatic cyc();
    bit rst_edge = !reset_n;
    last_tick = !rst_edge && (model_div == int'(SLOW_DIV) - 1);
    @(posedge clk_sys);
    #1;
    model_div = rst_edge ? 0 : (model_div + 1) % int'(SLOW_DIV);
    if (bus.sr_we === 1'b1) begin
      n_we++;
      chk("sr_we_expected", 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) begin
        chk("sr_write", 32'({bus.sr_addr, bus.sr_din}), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic cpu_write(input logic [7:0] b, input logic [15:0] a, input logic [7:0] d);
    bus.fast_clk = 1'b1;
    bus.we       = 1'b1;
    bus.bank     = b;
    bus.addr     = a;
    bus.dout     = d;
    if (model_hit(b, a, bus.shadow)) exp_q.push_back({b[0], a, d});
    cyc();
    idle();
  endtask

  task automatic wait_writes(input int n, input int max, input string tag);
    int start = n_we;
    for (int i = 0; i < max && n_we < start + n; i++) cyc();
    chk(tag, 32'(n_we - start), 32'(n));
  endtask

  task automatic quiet(input int ncyc, input string tag);
    int start = n_we;
    repeat (ncyc) cyc();
    chk(tag, 32'(n_we - start), 32'h0);
  endtask

  task automatic align_after_tick();
    for (int i = 0; i < 2 * int'(SLOW_DIV) && model_div != 0; i++) cyc();
  endtask

  initial begin
    int  start;
    bit  done;
    int  r;

    idle();
    bus.shadow = 8'h00;
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    chk("rst_sr_we", 32'(bus.sr_we), 32'h0);
    chk("rst_sr_addr", 32'(bus.sr_addr), 32'h0);
    chk("rst_sr_din", 32'(bus.sr_din), 32'h0);
    chk("rst_cpu_wait", 32'(bus.cpu_wait), 32'h0);
    chk("rst_level", 32'(bus.fifo_level), 32'h0);

    // text1 write drains one cycle after a slot tick, as a single pulse
    cpu_write(8'h00, 16'h0400, 8'h41);
    start = n_we;
    for (int i = 0; i < 2 * int'(SLOW_DIV) && n_we == start; i++) cyc();
    chk("text1_seen", 32'(n_we - start), 32'h1);
    chk("text1_after_tick", 32'(last_tick), 32'h1);
    chk("text1_addr", 32'(bus.sr_addr), 32'h00400);
    chk("text1_data", 32'(bus.sr_din), 32'h41);
    cyc();
    chk("text1_pulse", 32'(bus.sr_we), 32'h0);

    bus.shadow = 8'h01;
    cpu_write(8'h00, 16'h0500, 8'h5A);
    quiet(3 * int'(SLOW_DIV), "text1_inhibited");

    bus.shadow = 8'h00;
    cpu_write(8'h01, 16'h9000, 8'h77);
    wait_writes(1, 2 * int'(SLOW_DIV), "shr_aux_seen");
    chk("shr_aux_addr", 32'(bus.sr_addr), 32'h19000);
    cpu_write(8'h00, 16'h9000, 8'h66);
    quiet(3 * int'(SLOW_DIV), "shr_main_none");

    bus.shadow = 8'h18;
    cpu_write(8'h01, 16'h2000, 8'h12);
    quiet(3 * int'(SLOW_DIV), "auxhgr_inhibited");
    bus.shadow = 8'h00;

    // DEPTH+1 back-to-back hits: the last one lands in the skid
    align_after_tick();
    for (int i = 0; i < 5; i++) begin
      cpu_write(8'h00, 16'h2000 + 16'(i), 8'(i));
      if (i == 3) chk("no_wait_at_full", 32'(bus.cpu_wait), 32'h0);
    end
    chk("wait_on_skid", 32'(bus.cpu_wait), 32'h1);
    chk("level_full", 32'(bus.fifo_level), 32'(DEPTH));
    wait_writes(1, 2 * int'(SLOW_DIV), "skid_first_drain");
    chk("wait_held_first_drain", 32'(bus.cpu_wait), 32'h1);
    wait_writes(4, 6 * int'(SLOW_DIV), "skid_rest_drain");
    cyc();
    cyc();
    chk("skid_wait_released", 32'(bus.cpu_wait), 32'h0);
    chk("skid_level_empty", 32'(bus.fifo_level), 32'h0);

    // Read of E0 with three writes queued holds the CPU until the last write
    align_after_tick();
    for (int i = 0; i < 3; i++) cpu_write(8'h00, 16'h0400 + 16'(i), 8'hA0 + 8'(i));
    chk("read_level3", 32'(bus.fifo_level), 32'h3);
    bus.fast_clk = 1'b1;
    bus.we       = 1'b0;
    bus.bank     = 8'hE0;
    bus.addr     = 16'h0400;
    cyc();
    idle();
    chk("read_hold_set", 32'(bus.cpu_wait), 32'h1);
    start = n_we;
    done  = 1'b0;
    for (int i = 0; i < 6 * int'(SLOW_DIV) && !done; i++) begin
      cyc();
      if (n_we - start == 3) begin
        chk("read_hold_last_we", 32'(bus.cpu_wait), 32'h1);
        cyc();
        chk("read_hold_release", 32'(bus.cpu_wait), 32'h0);
        done = 1'b1;
      end
    end
    chk("read_hold_done", 32'(done), 32'h1);

    // Direct E0 access on the tick defers the drain by one cycle
    align_after_tick();
    cpu_write(8'h00, 16'h0800, 8'hC3);
    for (int i = 0; i < 2 * int'(SLOW_DIV) && model_div != int'(SLOW_DIV) - 1; i++) cyc();
    bus.fast_clk = 1'b1;
    bus.we       = 1'b1;
    bus.bank     = 8'hE0;
    bus.addr     = 16'h1234;
    bus.dout     = 8'hFF;
    cyc();
    idle();
    chk("collide_tick", 32'(last_tick), 32'h1);
    chk("collide_no_we", 32'(bus.sr_we), 32'h0);
    cyc();
    chk("deferred_we", 32'(bus.sr_we), 32'h1);
    chk("deferred_addr", 32'(bus.sr_addr), 32'h00800);

    // Reset with three queued writes discards them
    align_after_tick();
    for (int i = 0; i < 3; i++) cpu_write(8'h01, 16'h4000 + 16'(i), 8'h30 + 8'(i));
    chk("pre_reset_level", 32'(bus.fifo_level), 32'h3);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    exp_q.delete();
    chk("reset_level", 32'(bus.fifo_level), 32'h0);
    chk("reset_wait", 32'(bus.cpu_wait), 32'h0);
    chk("reset_sr_we", 32'(bus.sr_we), 32'h0);
    quiet(3 * int'(SLOW_DIV), "reset_no_writes");

    // Random traffic from a CPU that honours cpu_wait
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 9));
      if (bus.cpu_wait === 1'b0 && r < 5) begin
        bus.shadow = 8'($urandom) & 8'($urandom);
        cpu_write(rnd_banks[$urandom_range(0, 5)],
                  (r < 3) ? rnd_addrs[$urandom_range(0, 13)] : 16'($urandom),
                  8'($urandom));
      end else if (bus.cpu_wait === 1'b0 && r == 5) begin
        bus.fast_clk = 1'b1;
        bus.we       = 1'b0;
        bus.bank     = ($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hE1;
        bus.addr     = 16'($urandom);
        cyc();
        idle();
      end else begin
        cyc();
      end
    end
    for (int i = 0; i < 20 * int'(SLOW_DIV) && exp_q.size() != 0; i++) cyc();
    chk("random_drained", 32'(exp_q.size()), 32'h0);
    cyc();
    cyc();
    chk("random_wait_idle", 32'(bus.cpu_wait), 32'h0);
    chk("random_level_idle", 32'(bus.fifo_level), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/shadow_writer.md
Name: shadow_writer

Overview:
- Implements IIgs bank 00/01 → E0/E1 video shadowing, which the memory map currently lacks.
- Sits between the CPU bus (bank/addr/dout/we, qualified by fast_clk) and the slow-RAM write port.
- Captures fast-RAM writes that hit shadowed video regions, queues them in a small FIFO, and replays them into slow RAM at the 1 MHz slot rate.
- Stalls the CPU through a wait output when the queue overflows or when a slow-RAM read would bypass pending writes.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- SLOW_DIV, 14, clk_sys cycles per slow-RAM slot tick (≥2).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- fast_clk  in  1  one-cycle CPU bus-valid strobe
- bank  in  8  CPU bank
- addr  in  16  CPU address
- dout  in  8  CPU write data
- we  in  1  CPU write enable
- shadow  in  8  $C035 SHADOW register; bit=1 inhibits that region
- sr_addr  out  17  slow-RAM address {bank[0], addr}
- sr_din  out  8  slow-RAM write data
- sr_we  out  1  slow-RAM write strobe, one cycle
- cpu_wait  out  1  CPU stall request
- fifo_level  out  $clog2(DEPTH)+1  current occupancy (debug)

Behaviour:
- Reset (reset_n=0 at a clk_sys edge):
  - FIFO empty; divider=0; skid register empty.
  - sr_we=0, sr_addr=0, sr_din=0, cpu_wait=0, fifo_level=0.
- Shadow hit (combinational): fast_clk & we & (bank==00 | bank==01) & region enabled. Regions:
  - text1 0400–07FF: shadow[0]=0.
  - hgr1 2000–3FFF: shadow[1]=0; bank 01 additionally requires shadow[4]=0.
  - hgr2 4000–5FFF: shadow[2]=0; bank 01 additionally requires shadow[4]=0.
  - shr 2000–9FFF, bank 01 only: shadow[3]=0. This is an OR with hgr1/hgr2.
  - text2 0800–0BFF: shadow[5]=0.
  - Range bounds are inclusive; all other addresses never shadow.
- Push on hit:
  - Entry {bank[0], addr, dout} is written at that edge when FIFO is not full.
  - If FIFO is full: entry goes into a one-entry skid register and cpu_wait=1 from the next cycle. The skid moves into the FIFO on the first cycle a slot frees, and cpu_wait drops the cycle after that move.
  - A hit while the skid is occupied cannot occur because the CPU is held. If one does occur, it is dropped; the bench flags it as an error.
- Slot divider:
  - Counts 0..SLOW_DIV-1, wraps, free-running.
  - Tick when count==SLOW_DIV-1.
- Drain:
  - On tick with FIFO non-empty and no direct E0/E1 access this cycle (fast_clk & (bank==E0|E1)): pop head, drive sr_addr/sr_din, sr_we=1 for exactly one cycle (registered, latency 1 after tick).
  - If a direct access collides with a tick, the drain is deferred to the next non-colliding cycle, not the next tick.
- Simultaneous push and pop: both occur; occupancy unchanged; a full FIFO accepts the push (no skid).
- Read coherency:
  - fast_clk & ~we & (bank==E0|E1) with FIFO or skid non-empty sets cpu_wait=1 until both are empty.
  - cpu_wait deasserts the cycle after the final sr_we.
- cpu_wait = skid_full | read_hold; registered.
- Ordering: strict FIFO. Skid entries are always younger than FIFO entries.
- fifo_level counts FIFO entries only, excluding the skid; range 0..DEPTH.
- Reset mid-operation discards all queued writes; sr_we drops at the reset edge.

Decomposition:
- Package shadow_pkg:
  - SHADOW bit index constants (SH_TEXT1=0, SH_HGR1=1, SH_HGR2=2, SH_SHR=3, SH_AUXHGR=4, SH_TEXT2=5).
  - Region bound constants.
  - Entry struct {bank0, addr[15:0], data[7:0]}, 25 bits.
- Sub-module sync_fifo (DEPTH, WIDTH=25): push/pop/full/empty/level. Decode, divider, skid and wait logic live in shadow_writer.

Test Plan:
- shadow=00, bank 00 write 0x0400←0x41 → after next tick sr_we=1, sr_addr=0x00400, sr_din=0x41, one cycle.
- shadow=0x01, bank 00 write 0x0500 → no sr_we for 3·SLOW_DIV cycles. shadow=0x00, bank 01 write 0x9000 with shadow[3]=0 → sr_addr=0x19000. Same write on bank 00 → no write.
- DEPTH+1 back-to-back hits, addresses 0x2000..0x2004, data 0..4 → cpu_wait=1 the cycle after the 5th hit; five sr_we in address order; cpu_wait=0 after skid drains.
- Three queued writes, then fast_clk read of bank E0 → cpu_wait=1 until third sr_we; deasserts next cycle.
- Direct E0 write coinciding with tick, FIFO=1 entry → sr_we occurs the following cycle, not at the tick.
- reset_n=0 with FIFO=3 → next cycle fifo_level=0, cpu_wait=0, no sr_we afterwards.
